// File: rtl/poly_ram_loader.sv
// Write-side loader for the banked polynomial RAM: takes a valid/ready coefficient stream
// and scatters index j to bank j%NUM_BASE_BANK at address j/NUM_BASE_BANK.
module poly_ram_loader #(
    parameter int COE_WIDTH     = 39,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_BASE_BANK = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [COE_WIDTH-1:0]                in_data,
    output logic [NUM_BASE_BANK-1:0]            wea,
    output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] addra,
    output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  dina
);

    localparam int BANK_BITS = $clog2(NUM_BASE_BANK);
    localparam int IDX_W     = BANK_BITS + ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                   state, state_next;
    logic [IDX_W-1:0]         idx, idx_next;
    logic                     accept;
    logic [NUM_BASE_BANK-1:0] wea_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        accept     = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    idx_next   = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // abort takes priority: the beat presented alongside it is not consumed
                if (abort) begin
                    state_next = S_IDLE;
                end else if (in_valid) begin
                    accept   = 1'b1;
                    idx_next = idx + 1'b1;
                    if (idx == '1) begin
                        state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wea_next = '0;
        for (int unsigned k = 0; k < NUM_BASE_BANK; k++) begin
            wea_next[k] = accept && (idx[BANK_BITS-1:0] == BANK_BITS'(k));
        end
    end

    // Address and data are broadcast to every bank; only the enabled bank commits them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wea   <= '0;
            addra <= '0;
            dina  <= '0;
        end else begin
            wea <= wea_next;
            if (accept) begin
                addra <= {NUM_BASE_BANK{idx[IDX_W-1:BANK_BITS]}};
                dina  <= {NUM_BASE_BANK{in_data}};
            end
        end
    end

endmodule
